// File: rtl/mbox_pkg.sv
// Shared register offsets, STATUS bit positions, FSM states and the latched bus-access record
// for the AVR mailbox responder.
package mbox_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_TXDATA  = 2'd2;
    localparam logic [1:0] REG_RXCOUNT = 2'd3;

    localparam int STB_RX_NONEMPTY = 0;
    localparam int STB_TX_FULL     = 1;
    localparam int STB_TX_OVF      = 2;
    localparam int STB_TX_EMPTY    = 3;
    localparam int STB_FLUSH       = 7;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    typedef struct packed {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdat;
    } acc_t;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Sync FIFO with show-ahead head; push/pop/flush commit on the clock edge (no output latency).
// A push while full succeeds only alongside a pop; flush overrides both.
module mbox_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | pop) & ~flush;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/avr_mbox_slave.sv
// AVR SRAM-bus responder for an RX/TX byte mailbox; each access stalls WAIT_STATES cycles (WAIT_STATES+1 total).
// Fabric RX backpressured via rx_ready; MBOX_IRQ_EN makes offset 3 a writable IRQ_EN driving a registered irq.
module avr_mbox_slave
    import mbox_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sram_a,
    input  logic [7:0]  sram_d_out,
    output logic [7:0]  sram_d_in,
    input  logic        sram_cs,
    input  logic        sram_oe,
    input  logic        sram_we,
    output logic        sram_wait,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q;
    logic [7:0]    ctr_q;
    acc_t          acc_q;
    acc_t          acc_d;
    logic [7:0]    rd_q;
    logic [7:0]    rd_mux;
    logic [7:0]    status;
    logic          access;
    logic          done;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0] rx_count, tx_count;
    logic [7:0]    rx_head;
    logic          avr_rd_rx, avr_wr_tx, wr_status, flush;
    logic          rx_pop_eff, ovf_set, tx_ovf_q;
    logic          unused_ok;

    assign unused_ok = ^{sram_a[15:2], tx_count};

    assign access = sram_cs & (sram_oe | sram_we);
    assign acc_d  = '{wr: sram_we, addr: sram_a[1:0], wdat: sram_d_out};
    assign done   = (state_q == ST_DONE);

    // Stall starts combinationally on the first access cycle; reset drops it without waiting for a clock.
    assign sram_wait = ~rst & (((state_q == ST_IDLE) & access) | (state_q == ST_WAIT));
    assign sram_d_in = rd_q;

    always_comb begin
        status                  = '0;
        status[STB_RX_NONEMPTY] = ~rx_empty;
        status[STB_TX_FULL]     = tx_full;
        status[STB_TX_OVF]      = tx_ovf_q;
        status[STB_TX_EMPTY]    = tx_empty;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (sram_a[1:0])
            REG_STATUS:  rd_mux = status;
            REG_RXDATA:  rd_mux = rx_empty ? 8'h00 : rx_head;
            REG_RXCOUNT: rd_mux = sat8(32'(rx_count));
            default:     rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            acc_q   <= '0;
            rd_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        acc_q <= acc_d;
                        ctr_q <= 8'd1;
                        if (!sram_we) begin
                            rd_q <= rd_mux;
                        end
                        state_q <= (WAIT_STATES == 1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    ctr_q <= ctr_q + 8'd1;
                    if (ctr_q + 8'd1 == 8'(WAIT_STATES)) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Side effects fire only in the single DONE cycle of an access.
    assign avr_rd_rx  = done & ~acc_q.wr & (acc_q.addr == REG_RXDATA);
    assign avr_wr_tx  = done &  acc_q.wr & (acc_q.addr == REG_TXDATA);
    assign wr_status  = done &  acc_q.wr & (acc_q.addr == REG_STATUS);
    assign flush      = wr_status & acc_q.wdat[STB_FLUSH];
    assign rx_pop_eff = avr_rd_rx & ~rx_empty;

    // A same-cycle AVR pop frees a slot, so a full RX still accepts the fabric byte.
    assign rx_ready = (~rx_full | rx_pop_eff) & ~flush;
    assign tx_valid = ~tx_empty;
    assign ovf_set  = avr_wr_tx & tx_full & ~tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
        end else if (wr_status & acc_q.wdat[STB_TX_OVF]) begin
            tx_ovf_q <= 1'b0;
        end else if (ovf_set) begin
            tx_ovf_q <= 1'b1;
        end
    end

    mbox_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_valid & rx_ready),
        .push_dat (rx_data),
        .pop      (avr_rd_rx),
        .flush    (flush),
        .head     (rx_head),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    mbox_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (avr_wr_tx),
        .push_dat (acc_q.wdat),
        .pop      (tx_ready),
        .flush    (flush),
        .head     (tx_data),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

`ifdef MBOX_IRQ_EN
    logic [1:0] irq_en_q;
    logic       irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (done & acc_q.wr & (acc_q.addr == REG_RXCOUNT)) begin
                irq_en_q <= acc_q.wdat[1:0];
            end
            irq_q <= |(irq_en_q & {tx_empty, ~rx_empty});
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_avr_mbox_slave.sv
// Directed bench for avr_mbox_slave: queue-based mailbox model checked every cycle plus literal expectations.
module tb_avr_mbox_slave;

    localparam int D  = 16;
    localparam int WS = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] sram_a;
    logic [7:0]  sram_d_out;
    logic [7:0]  sram_d_in;
    logic        sram_cs, sram_oe, sram_we;
    logic        sram_wait;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    logic        rst3;
    logic [15:0] sram_a3;
    logic [7:0]  sram_d_out3;
    logic [7:0]  sram_d_in3;
    logic        sram_cs3, sram_oe3, sram_we3;
    logic        sram_wait3;
    logic [7:0]  rx_data3;
    logic        rx_valid3;
    logic        rx_ready3;
    logic [7:0]  tx_data3;
    logic        tx_valid3;
    logic        tx_ready3;
    logic        irq3;

    avr_mbox_slave #(.FIFO_DEPTH(D), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst(rst), .sram_a(sram_a), .sram_d_out(sram_d_out), .sram_d_in(sram_d_in),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we), .sram_wait(sram_wait),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );

    avr_mbox_slave #(.FIFO_DEPTH(D), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .sram_a(sram_a3), .sram_d_out(sram_d_out3), .sram_d_in(sram_d_in3),
        .sram_cs(sram_cs3), .sram_oe(sram_oe3), .sram_we(sram_we3), .sram_wait(sram_wait3),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3), .irq(irq3)
    );

    int tests  = 0;
    int errors = 0;
    int last_wait;
    bit chk_en = 1'b0;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- mailbox model (u_dut) ----------------
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_ovf;
    bit   [1:0] m_irq_en;
    bit         m_irq;
    int         phase;
    bit         a_wr;
    logic [1:0] a_ad;
    logic [7:0] a_wd;
    logic [7:0] m_rd;

    function automatic logic [7:0] m_read(input logic [1:0] ad);
        case (ad)
            2'd0:    return {4'b0000, txq.size() == 0, m_ovf, txq.size() == D, rxq.size() != 0};
            2'd1:    return (rxq.size() > 0) ? rxq[0] : 8'h00;
            2'd2:    return 8'h00;
            default: return (rxq.size() > 255) ? 8'hFF : 8'(rxq.size());
        endcase
    endfunction

    function automatic bit m_done();
        return phase == WS;
    endfunction

    function automatic bit m_flush();
        return m_done() && a_wr && a_ad == 2'd0 && a_wd[7];
    endfunction

    function automatic bit m_rxpop();
        return m_done() && !a_wr && a_ad == 2'd1 && rxq.size() > 0;
    endfunction

    function automatic bit m_rx_ready();
        return (rxq.size() < D || m_rxpop()) && !m_flush();
    endfunction

    function automatic bit m_wait();
        return (phase == 0 && sram_cs && (sram_oe || sram_we)) || (phase > 0 && phase < WS);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            rxq.delete();
            txq.delete();
            m_ovf    = 1'b0;
            m_irq_en = 2'b00;
            m_irq    = 1'b0;
            phase    = 0;
        end else begin
            bit acc, done, flush, rxpop, fpush, tpop;
            acc   = sram_cs && (sram_oe || sram_we);
            done  = m_done();
            flush = m_flush();
            rxpop = m_rxpop();
            fpush = rx_valid && m_rx_ready();
            tpop  = tx_ready && txq.size() > 0;
            m_irq = |(m_irq_en & {txq.size() == 0, rxq.size() != 0});
            if (phase == 0 && acc) begin
                a_wr = sram_we;
                a_ad = sram_a[1:0];
                a_wd = sram_d_out;
                if (!sram_we) m_rd = m_read(sram_a[1:0]);
            end
            if (flush) begin
                rxq.delete();
                txq.delete();
            end else begin
                if (rxpop) void'(rxq.pop_front());
                if (fpush) rxq.push_back(rx_data);
                if (tpop) void'(txq.pop_front());
                if (done && a_wr && a_ad == 2'd2) begin
                    if (txq.size() < D) txq.push_back(a_wd);
                    else m_ovf = 1'b1;
                end
            end
            if (done && a_wr && a_ad == 2'd0 && a_wd[2]) m_ovf = 1'b0;
`ifdef MBOX_IRQ_EN
            if (done && a_wr && a_ad == 2'd3) m_irq_en = a_wd[1:0];
`endif
            if (done) phase = 0;
            else if (phase > 0) phase++;
            else if (acc) phase = 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk1("m_sram_wait", sram_wait, m_wait());
            chk1("m_rx_ready", rx_ready, m_rx_ready());
            chk1("m_tx_valid", tx_valid, txq.size() > 0);
            if (txq.size() > 0) chk8("m_tx_data", tx_data, txq[0]);
            chk1("m_irq", irq, m_irq);
            if (m_done() && !a_wr) chk8("m_rd_data", sram_d_in, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic avr_acc(input bit wr, input logic [1:0] ad, input logic [7:0] wd, output logic [7:0] rd);
        int n;
        @(posedge clk); #1;
        sram_cs = 1'b1; sram_we = wr; sram_oe = !wr;
        sram_a = {14'h0, ad}; sram_d_out = wd;
        n = 0;
        @(negedge clk);
        while (sram_wait && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++; errors++;
            $display("FAIL bus_timeout: sram_wait stuck high, limit 40 cycles");
        end
        rd = sram_d_in;
        last_wait = n;
        @(posedge clk); #1;
        sram_cs = 1'b0; sram_we = 1'b0; sram_oe = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] ad, output logic [7:0] rd);
        avr_acc(1'b0, ad, 8'h00, rd);
    endtask

    task automatic wr_reg(input logic [1:0] ad, input logic [7:0] wd);
        logic [7:0] dummy;
        avr_acc(1'b1, ad, wd, dummy);
    endtask

    task automatic fab_push(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic acc3(input logic [1:0] ad, output logic [7:0] rd, output int n);
        @(posedge clk); #1;
        sram_cs3 = 1'b1; sram_oe3 = 1'b1; sram_a3 = {14'h0, ad};
        n = 0;
        @(negedge clk);
        while (sram_wait3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++; errors++;
            $display("FAIL bus3_timeout: sram_wait stuck high, limit 40 cycles");
        end
        rd = sram_d_in3;
        @(posedge clk); #1;
        sram_cs3 = 1'b0; sram_oe3 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int n3;
        rst = 1'b1; rst3 = 1'b1;
        sram_a = '0; sram_d_out = '0; sram_cs = 0; sram_oe = 0; sram_we = 0;
        rx_data = '0; rx_valid = 0; tx_ready = 0;
        sram_a3 = '0; sram_d_out3 = '0; sram_cs3 = 0; sram_oe3 = 0; sram_we3 = 0;
        rx_data3 = '0; rx_valid3 = 0; tx_ready3 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_sram_wait", sram_wait, 1'b0);
        chk8("rst_sram_d_in", sram_d_in, 8'h00);
        chk1("rst_rx_ready", rx_ready, 1'b1);
        chk1("rst_tx_valid", tx_valid, 1'b0);
        chk1("rst_irq", irq, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; rst3 = 1'b0; chk_en = 1'b1;

        rd_reg(2'd0, rd);
        chk8("status_after_reset", rd, 8'h08);
        chk8("wait_cycles_ws1", 8'(last_wait), 8'd1);

        fab_push(8'hA5);
        fab_push(8'h5A);
        rd_reg(2'd1, rd); chk8("rxdata_first", rd, 8'hA5);
        rd_reg(2'd1, rd); chk8("rxdata_second", rd, 8'h5A);
        rd_reg(2'd3, rd); chk8("rxcount_drained", rd, 8'h00);
        rd_reg(2'd0, rd); chk8("status_rx_empty", rd, 8'h08);
        rd_reg(2'd1, rd); chk8("rxdata_empty_read", rd, 8'h00);
        rd_reg(2'd2, rd); chk8("txdata_read_zero", rd, 8'h00);

        for (int i = 0; i < 17; i++) wr_reg(2'd2, 8'(8'h40 + i));
        rd_reg(2'd0, rd); chk8("status_tx_ovf", rd, 8'h06);
        wr_reg(2'd0, 8'h04);
        rd_reg(2'd0, rd); chk8("status_ovf_cleared", rd, 8'h02);

        for (int i = 0; i < 16; i++) fab_push(8'(8'hC0 + i));
        chk1("rx_full_not_ready", rx_ready, 1'b0);
        rd_reg(2'd3, rd); chk8("rxcount_full", rd, 8'h10);

        @(posedge clk); #1;
        sram_cs = 1'b1; sram_oe = 1'b1; sram_a = 16'h0001;
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h33;
        @(negedge clk);
        chk1("rx_full_pop_ready", rx_ready, 1'b1);
        chk8("rx_full_pop_data", sram_d_in, 8'hC0);
        @(posedge clk); #1;
        sram_cs = 1'b0; sram_oe = 1'b0; rx_valid = 1'b0;
        rd_reg(2'd3, rd); chk8("rxcount_push_pop", rd, 8'h10);

        @(posedge clk); #1;
        sram_cs = 1'b1; sram_we = 1'b1; sram_a = 16'h0002; sram_d_out = 8'h77;
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk8("tx_full_pop_head", tx_data, 8'h40);
        @(posedge clk); #1;
        sram_cs = 1'b0; sram_we = 1'b0; tx_ready = 1'b0;
        rd_reg(2'd0, rd); chk8("status_full_push_pop", rd, 8'h03);

        wr_reg(2'd0, 8'h80);
        chk1("flush_tx_valid", tx_valid, 1'b0);
        rd_reg(2'd3, rd); chk8("flush_rxcount", rd, 8'h00);
        rd_reg(2'd0, rd); chk8("flush_status", rd, 8'h08);

        tx_ready = 1'b1;
        wr_reg(2'd2, 8'h11);
        chk1("tx_stream_valid", tx_valid, 1'b1);
        chk8("tx_stream_data", tx_data, 8'h11);

        wr_reg(2'd3, 8'h01);
        fab_push(8'h99);
        chk1("irq_not_yet", irq, 1'b0);
        @(posedge clk); #1;
`ifdef MBOX_IRQ_EN
        chk1("irq_rx_nonempty", irq, 1'b1);
`else
        chk1("irq_tied_low", irq, 1'b0);
`endif
        rd_reg(2'd3, rd); chk8("rxcount_after_irq_write", rd, 8'h01);

        @(posedge clk); #1;
        rx_valid3 = 1'b1; rx_data3 = 8'h5C;
        @(posedge clk); #1;
        rx_valid3 = 1'b0;
        acc3(2'd3, rd, n3);
        chk8("ws3_rxcount", rd, 8'h01);
        chk8("ws3_wait_cycles", 8'(n3), 8'd3);
        @(posedge clk); #1;
        sram_cs3 = 1'b1; sram_oe3 = 1'b1; sram_a3 = 16'h0001;
        @(negedge clk); chk1("ws3_wait_idle", sram_wait3, 1'b1);
        @(negedge clk); chk1("ws3_wait_wait", sram_wait3, 1'b1);
        #1 rst3 = 1'b1;
        #1 chk1("ws3_wait_async_rst", sram_wait3, 1'b0);
        @(negedge clk);
        chk1("ws3_wait_held_rst", sram_wait3, 1'b0);
        chk8("ws3_d_in_rst", sram_d_in3, 8'h00);
        @(posedge clk); #1;
        sram_cs3 = 1'b0; sram_oe3 = 1'b0; rst3 = 1'b0;
        acc3(2'd0, rd, n3);
        chk8("ws3_status_after_rst", rd, 8'h08);
        chk8("ws3_wait_cycles_after_rst", 8'(n3), 8'd3);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
